// File: rtl/vscale_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vscale_dmem_responder_pkg
// Brief    : Shared size codes, FSM state encoding and parameter limits for
//            the vscale data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package vscale_dmem_responder_pkg;

  // Access size codes carried on dmem_size; anything above word is illegal.
  localparam logic [2:0] c_size_byte = 3'd0;
  localparam logic [2:0] c_size_half = 3'd1;
  localparam logic [2:0] c_size_word = 3'd2;

  // Parameter limits.
  localparam int c_max_wait_cycles = 15;
  localparam int c_min_depth_words = 1;

  // Responder FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vscale_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : vscale_dmem_responder_if
// Brief    : Pipelined data-memory bus between the core (master) and the
//            memory responder (slave).
// Revision : 1.0  initial release
// ============================================================================
interface vscale_dmem_responder_if;

  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  modport master (
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_rdata, dmem_wait, dmem_badmem_e
  );

  modport slave (
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_rdata, dmem_wait, dmem_badmem_e
  );

endinterface
`default_nettype wire

// File: rtl/vscale_dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : vscale_dmem_array
// Brief    : Word-organised backing store with one byte-enabled synchronous
//            write port and one asynchronous read port. No reset: contents
//            are undefined until written.
// Revision : 1.0  initial release
// ============================================================================
module vscale_dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [3:0]        be,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [31:0]       wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic [31:0]            rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/vscale_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vscale_dmem_responder
// Brief    : Data-memory responder for the vscale pipelined bus. Registers the
//            address phase, inserts WAIT_CYCLES wait states, then completes
//            the data phase in a single RESP cycle (load data / store commit /
//            access-error flag).
// Revision : 1.0  initial release
// ============================================================================
module vscale_dmem_responder
  import vscale_dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  wire logic               clk,
  input  wire logic               reset,
  vscale_dmem_responder_if.slave  dmem
);

  localparam int         c_aw           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] c_wait_load    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam state_t     c_accept_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
  localparam logic       c_accept_wait  = (WAIT_CYCLES > 0);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wait;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic        r_wen;

  logic            w_accept;
  logic [31:0]     w_offset;
  logic            w_bad_size;
  logic            w_misaligned;
  logic            w_below_base;
  logic            w_out_of_range;
  logic            w_bad;
  logic [3:0]      w_be;
  logic            w_we;
  logic [c_aw-1:0] w_word_idx;
  logic [31:0]     w_rd_word;
  logic            w_unused_offset;

  // A new address phase is taken whenever no stall is being signalled;
  // reset blocks acceptance because the FSM reset branch wins.
  assign w_accept = dmem.dmem_en && !r_wait;

  // Request register and IDLE/WAIT/RESP sequencing with registered wait flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wait  <= 1'b0;
      r_addr  <= 32'h0;
      r_size  <= 3'd0;
      r_wen   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_addr  <= dmem.dmem_addr;
            r_size  <= dmem.dmem_size;
            r_wen   <= dmem.dmem_wen;
            r_cnt   <= c_wait_load;
            r_state <= c_accept_state;
            r_wait  <= c_accept_wait;
          end else begin
            r_state <= S_IDLE;
            r_wait  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_wait  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wait  <= 1'b0;
        end
      endcase
    end
  end

  // Access-error decode on the registered request.
  always_comb begin
    w_offset       = r_addr - BASE_ADDR;
    w_below_base   = (r_addr < BASE_ADDR);
    w_out_of_range = ({2'b00, w_offset[31:2]} >= 32'(DEPTH_WORDS));
    w_bad_size     = 1'b0;
    w_misaligned   = 1'b0;
    case (r_size)
      c_size_byte: w_misaligned = 1'b0;
      c_size_half: w_misaligned = r_addr[0];
      c_size_word: w_misaligned = |r_addr[1:0];
      default:     w_bad_size   = 1'b1;
    endcase
    w_bad = w_bad_size || w_misaligned || w_below_base || w_out_of_range;
  end

  // Byte enables follow the absolute address lanes of the registered request.
  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      c_size_byte: w_be = 4'b0001 << r_addr[1:0];
      c_size_half: w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      c_size_word: w_be = 4'b1111;
      default:     w_be = 4'b0000;
    endcase
  end

  assign w_word_idx      = w_offset[c_aw+1:2];
  assign w_unused_offset = ^w_offset[1:0];

  // Stores commit on the edge that ends RESP; reset in that cycle aborts them.
  assign w_we = (r_state == S_RESP) && r_wen && !w_bad && !reset;

  vscale_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (c_aw)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .be    (w_be),
    .waddr (w_word_idx),
    .wdata (dmem.dmem_wdata_delayed),
    .raddr (w_word_idx),
    .rdata (w_rd_word)
  );

  assign dmem.dmem_wait     = r_wait;
  assign dmem.dmem_badmem_e = (r_state == S_RESP) && w_bad;
  assign dmem.dmem_rdata    = ((r_state == S_RESP) && !r_wen && !w_bad) ? w_rd_word : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_vscale_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vscale_dmem_responder
// Brief    : Self-checking bench: four responders with different wait-state
//            and base settings, driven one at a time by a request queue and
//            compared every cycle against a byte-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vscale_dmem_responder;
  import vscale_dmem_responder_pkg::*;

  localparam int          c_n     = 4;
  localparam int          c_depth = 64;
  localparam int          c_wait [c_n] = '{0, 3, 1, 5};
  localparam logic [31:0] c_base [c_n] = '{32'h0, 32'h0, 32'h40, 32'h0};

  typedef struct {
    bit          bubble;
    bit          wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [c_n];
  logic        en    [c_n];
  logic        wen   [c_n];
  logic [2:0]  size  [c_n];
  logic [31:0] addr  [c_n];
  logic [31:0] wdata [c_n];
  logic [31:0] rd    [c_n];
  logic        wt    [c_n];
  logic        bd    [c_n];

  generate
    for (genvar gi = 0; gi < c_n; gi++) begin : g_dut
      vscale_dmem_responder_if bus ();
      assign bus.dmem_en            = en[gi];
      assign bus.dmem_wen           = wen[gi];
      assign bus.dmem_size          = size[gi];
      assign bus.dmem_addr          = addr[gi];
      assign bus.dmem_wdata_delayed = wdata[gi];
      assign rd[gi]                 = bus.dmem_rdata;
      assign wt[gi]                 = bus.dmem_wait;
      assign bd[gi]                 = bus.dmem_badmem_e;
      vscale_dmem_responder #(
        .DEPTH_WORDS (c_depth),
        .BASE_ADDR   (c_base[gi]),
        .WAIT_CYCLES (c_wait[gi])
      ) u_dut (
        .clk   (clk),
        .reset (rst[gi]),
        .dmem  (bus.slave)
      );
    end
  endgenerate

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model [c_n][c_depth*4];
  req_t        pend [$];
  bit          have_dp = 0;
  req_t        dp;
  int          dp_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_bad = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input int k, input logic [31:0] a, input logic [2:0] s);
    logic [31:0] off;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && a % 2 != 0) return 1'b1;
    if (s == 3'd2 && a % 4 != 0) return 1'b1;
    if (a < c_base[k]) return 1'b1;
    off = a - c_base[k];
    return (off / 4) >= c_depth;
  endfunction

  function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
    int off;
    off = int'((a - c_base[k]) / 4) * 4;
    return {model[k][off+3], model[k][off+2], model[k][off+1], model[k][off]};
  endfunction

  task automatic model_store(input int k, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int nbytes, off, lane;
    nbytes = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) begin
      off  = int'(a - c_base[k]) + i;
      lane = int'((a + 32'(i)) % 4);
      model[k][off] = wd[8*lane +: 8];
    end
  endtask

  task automatic drive(input int k, input bit e, input bit w, input logic [2:0] s, input logic [31:0] a);
    en[k] = e; wen[k] = w; size[k] = s; addr[k] = a;
  endtask

  task automatic drive_idle(input int k);
    drive(k, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom());
  endtask

  task automatic push(input bit w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.bubble = 1'b0; r.wen = w; r.size = s; r.addr = a; r.wdata = wd;
    pend.push_back(r);
  endtask

  task automatic push_bubble();
    req_t r;
    r.bubble = 1'b1; r.wen = 1'b0; r.size = 3'd0; r.addr = 32'h0; r.wdata = 32'h0;
    pend.push_back(r);
  endtask

  // One bus cycle on instance k: check outputs, advance the model, drive inputs.
  task automatic step(input int k, input bit do_reset);
    int          phase;
    logic        exp_bad;
    logic [31:0] exp_rd;
    req_t        nx;
    @(negedge clk);
    if (!have_dp)        phase = 0;
    else if (dp_cnt > 0) phase = 1;
    else                 phase = 2;
    exp_bad = (phase == 2) && is_bad(k, dp.addr, dp.size);
    exp_rd  = (phase == 2 && !dp.wen && !exp_bad) ? model_word(k, dp.addr) : 32'h0;
    chk("wait",   {31'b0, wt[k]}, (phase == 1) ? 32'h1 : 32'h0);
    chk("badmem", {31'b0, bd[k]}, {31'b0, exp_bad});
    chk("rdata",  rd[k], exp_rd);
    if (phase == 2) begin
      last_rdata = rd[k];
      last_bad   = bd[k];
    end
    wdata[k] = have_dp ? dp.wdata : $urandom();
    if (do_reset) begin
      rst[k] = 1'b1;
      drive(k, 1'b1, 1'($urandom_range(0, 1)), 3'd2, c_base[k] + 32'h8);
      have_dp = 0;
    end else begin
      rst[k] = 1'b0;
      if (phase == 1) begin
        dp_cnt--;
        if (pend.size() > 0 && !pend[0].bubble)
          drive(k, 1'b1, pend[0].wen, pend[0].size, pend[0].addr);
        else
          drive_idle(k);
      end else begin
        if (phase == 2 && dp.wen && !exp_bad) model_store(k, dp.addr, dp.size, dp.wdata);
        have_dp = 0;
        if (pend.size() > 0) begin
          nx = pend.pop_front();
          if (nx.bubble) begin
            drive_idle(k);
          end else begin
            drive(k, 1'b1, nx.wen, nx.size, nx.addr);
            have_dp = 1;
            dp      = nx;
            dp_cnt  = c_wait[k];
          end
        end else begin
          drive_idle(k);
        end
      end
    end
  endtask

  task automatic drain(input int k);
    int guard = 0;
    while ((pend.size() > 0 || have_dp) && guard < 5000) begin
      step(k, 1'b0);
      guard++;
    end
    if (guard >= 5000) chk("drain_timeout", 32'(guard), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    // Requests presented while reset is held must be ignored.
    for (int k = 0; k < c_n; k++) begin
      rst[k] = 1'b1; en[k] = 1'b1; wen[k] = 1'b0; size[k] = 3'd2;
      addr[k] = c_base[k]; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < c_n; k++) begin
      chk("rst_wait",  {31'b0, wt[k]}, 32'h0);
      chk("rst_bad",   {31'b0, bd[k]}, 32'h0);
      chk("rst_rdata", rd[k], 32'h0);
      rst[k] = 1'b0;
      en[k]  = 1'b0;
    end

    // Give every word a known value so all later loads are predictable.
    for (int k = 0; k < c_n; k++) begin
      for (int w = 0; w < c_depth; w++) push(1'b1, c_size_word, c_base[k] + 32'(4*w), $urandom());
      drain(k);
    end

    // Zero wait states: store then immediate load of the same word.
    push(1'b1, c_size_word, 32'h10, 32'hDEADBEEF);
    push(1'b0, c_size_word, 32'h10, 32'h0);
    drain(0);
    chk("st_ld_b2b", last_rdata, 32'hDEADBEEF);

    // Byte store into the top lane of a word.
    push(1'b1, c_size_word, 32'h10, 32'h11223344);
    push(1'b1, c_size_byte, 32'h13, 32'h5A5A5A5A);
    push(1'b0, c_size_word, 32'h10, 32'h0);
    drain(0);
    chk("byte_merge", last_rdata, 32'h5A223344);

    // Error cases: misaligned half/word, illegal size, past the end.
    push(1'b1, c_size_half, 32'h21, 32'hFFFFFFFF); drain(0); chk("bad_half",  {31'b0, last_bad}, 32'h1);
    push(1'b0, c_size_word, 32'h22, 32'h0);        drain(0); chk("bad_word",  {31'b0, last_bad}, 32'h1);
    push(1'b0, 3'd3,        32'h0,  32'h0);        drain(0); chk("bad_size",  {31'b0, last_bad}, 32'h1);
    push(1'b0, c_size_word, 32'(c_depth*4), 32'h0); drain(0); chk("bad_range", {31'b0, last_bad}, 32'h1);
    push(1'b0, c_size_word, 32'h20, 32'h0);        drain(0); chk("bad_nowrite", last_rdata, model_word(0, 32'h20));

    // Three wait states with the following request held during the stall.
    push(1'b0, c_size_word, 32'h20, 32'h0);
    push(1'b0, c_size_word, 32'h24, 32'h0);
    drain(1);

    // Reset in the second wait cycle of a store aborts it.
    push(1'b1, c_size_word, 32'h30, 32'hCAFEF00D);
    drain(1);
    push(1'b1, c_size_word, 32'h30, 32'h0BADF00D);
    step(1, 1'b0);
    step(1, 1'b0);
    step(1, 1'b1);
    step(1, 1'b0);
    chk("rst_abort_wait", {31'b0, wt[1]}, 32'h0);
    push(1'b0, c_size_word, 32'h30, 32'h0);
    drain(1);
    chk("rst_abort_data", last_rdata, 32'hCAFEF00D);

    // Random back-to-back traffic on every instance.
    for (int k = 0; k < c_n; k++) begin
      for (int i = 0; i < 300; i++) begin
        int sel;
        if ($urandom_range(0, 4) == 0) begin
          push_bubble();
        end else begin
          sel = $urandom_range(0, 9);
          if (sel == 0)      a = (c_base[k] > 0) ? c_base[k] - 32'd4 : 32'hFFFF_FFF0;
          else if (sel == 1) a = c_base[k] + 32'(c_depth*4) + 32'($urandom_range(0, 15));
          else               a = c_base[k] + 32'($urandom_range(0, c_depth*4 - 1));
          push(1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
               a, $urandom());
        end
      end
      drain(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
